// File: rtl/delay_sweep_controller.sv
// Sweeps {a,b,c} = 0..7 into a 3-input gate block, samples y after a settle window and scores it.
// Define SWEEP_LATENCY_MEAS_EN to also measure the worst cycles-to-last-y-edge into max_latency.
module delay_sweep_controller #(
    parameter int         SETTLE_W = 8,
    parameter logic [7:0] EXPECTED = 8'h31
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic                dut_a,
    output logic                dut_b,
    output logic                dut_c,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [3:0]          err_count,
    output logic [7:0]          fail_mask,
    output logic [SETTLE_W-1:0] max_latency
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_e;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] s_q, s_d, cnt_q, cnt_d;
    logic [2:0]          vec_q, vec_d, drv_q, drv_d;
    logic [3:0]          err_q, err_d;
    logic [7:0]          mask_q, mask_d;
    logic                pass_q, pass_d;
    logic                accept;

    assign accept = (state_q == IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: assigning a default first keeps combinational processes free of inferred latches.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   state_d = abort ? IDLE : SETTLE;
            SETTLE:  if (abort) state_d = IDLE;
                     else if (cnt_q == SETTLE_W'(1)) state_d = SAMPLE;
            SAMPLE:  if (abort) state_d = IDLE;
                     else state_d = (vec_q == 3'd7) ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
        done = (state_q == DONE);
    end

    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        drv_d  = drv_q;
        err_d  = err_q;
        mask_d = mask_q;
        pass_d = pass_q;
        if (accept) begin
            s_d    = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
            vec_d  = 3'd0;
            err_d  = 4'd0;
            mask_d = 8'h00;
            pass_d = 1'b0;
        end else if (busy && abort) begin
            // Partial err_count/fail_mask are kept for diagnosis of the aborted sweep.
            drv_d  = 3'd0;
            pass_d = 1'b0;
        end else begin
            case (state_q)
                DRIVE: begin
                    drv_d = vec_q;
                    cnt_d = s_q;
                end
                SETTLE: cnt_d = cnt_q - SETTLE_W'(1);
                SAMPLE: begin
                    if (dut_y != EXPECTED[vec_q]) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_q + 4'd1;
                    end
                    if (vec_q != 3'd7) vec_d = vec_q + 3'd1;
                end
                DONE:    pass_d = (err_q == 4'd0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_q    <= '0;
            cnt_q  <= '0;
            vec_q  <= 3'd0;
            drv_q  <= 3'd0;
            err_q  <= 4'd0;
            mask_q <= 8'h00;
            pass_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            drv_q  <= drv_d;
            err_q  <= err_d;
            mask_q <= mask_d;
            pass_q <= pass_d;
        end
    end

    assign {dut_a, dut_b, dut_c} = drv_q;
    assign err_count             = err_q;
    assign fail_mask             = mask_q;
    assign pass                  = pass_q;

`ifdef SWEEP_LATENCY_MEAS_EN
    logic [SETTLE_W-1:0] lat_q, lat_v_q, max_q, lat_inc, lat_v_now;
    logic                y_prev_q, measuring, y_edge;

    assign measuring = (state_q == SETTLE) || (state_q == SAMPLE);
    assign y_edge    = measuring && (dut_y != y_prev_q);
    // The cycle in which an edge lands counts, so an edge in the first settle cycle reports 1.
    assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + SETTLE_W'(1);
    assign lat_v_now = y_edge ? lat_inc : lat_v_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_q    <= '0;
            lat_v_q  <= '0;
            max_q    <= '0;
            y_prev_q <= 1'b0;
        end else begin
            y_prev_q <= dut_y;
            if (accept) max_q <= '0;
            if (state_q == DRIVE) begin
                lat_q   <= '0;
                lat_v_q <= '0;
            end else if (measuring) begin
                lat_q   <= lat_inc;
                lat_v_q <= lat_v_now;
                if ((state_q == SAMPLE) && (lat_v_now > max_q)) max_q <= lat_v_now;
            end
        end
    end

    assign max_latency = max_q;
`else
    assign max_latency = '0;
`endif

endmodule
